// File: rtl/conv_layer_scheduler.sv
// rtl/conv_layer_scheduler.sv - sequences one conv layer kernel-by-kernel through the conv CU
// Handles CU reset, kernel-load handshake, per-kernel watchdog and abort; every output is a register.
module conv_layer_scheduler #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] cfg_chan_choose,
    input  logic [2:0] cfg_img_choose,
    input  logic [8:0] cfg_out_ch,
    input  logic       slave_select,
    input  logic       Kernel_BRAM_IDLE,
    input  logic       conv_DONE,
    output logic       Reset_top,
    output logic       Load_kernel_BRAM,
    output logic [1:0] CHANNEL_SIZE_choose,
    output logic [2:0] IMAGE_SIZE_choose,
    output logic [8:0] out_ch_index,
    output logic       layer_busy,
    output logic       layer_done,
    output logic       cfg_err,
    output logic       timeout_err
);
    typedef enum logic [2:0] {
        IDLE, RESET_CU, WAIT_CU_IDLE, ISSUE, RUN, NEXT, DONE, ABORT
    } state_t;

    state_t      r_state;
    logic        r_phase;
    logic [8:0]  r_out_ch;
    logic [23:0] r_wd;
    logic        r_reset_top;
    logic        r_load;
    logic [1:0]  r_chan;
    logic [2:0]  r_img;
    logic [8:0]  r_idx;
    logic        r_busy;
    logic        r_done;
    logic        r_cfg_err;
    logic        r_timeout_err;

    logic        w_cfg_ok;
    logic [23:0] w_wd_next;
    logic        w_timeout;
    logic [8:0]  w_last_idx;

    assign w_cfg_ok   = (cfg_chan_choose != 2'd3) && (cfg_img_choose <= 3'd5) &&
                        (cfg_out_ch != 9'd0) && (cfg_out_ch <= 9'd256);
    assign w_wd_next  = r_wd + 24'd1;
    assign w_timeout  = (w_wd_next == TIMEOUT_CYCLES);
    assign w_last_idx = r_out_ch - 9'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_phase       <= 1'b0;
            r_out_ch      <= 9'd0;
            r_wd          <= 24'd0;
            r_reset_top   <= 1'b0;
            r_load        <= 1'b0;
            r_chan        <= 2'd0;
            r_img         <= 3'd0;
            r_idx         <= 9'd0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_cfg_err     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            if (abort && !(r_state inside {IDLE, DONE, ABORT})) begin
                r_state     <= ABORT;
                r_reset_top <= 1'b0;
                r_load      <= 1'b0;
                r_phase     <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_reset_top <= 1'b1;
                        if (start) begin
                            if (w_cfg_ok) begin
                                r_chan        <= cfg_chan_choose;
                                r_img         <= cfg_img_choose;
                                r_out_ch      <= cfg_out_ch;
                                r_idx         <= 9'd0;
                                r_timeout_err <= 1'b0;
                                r_busy        <= 1'b1;
                                r_reset_top   <= 1'b0;
                                r_phase       <= 1'b0;
                                r_state       <= RESET_CU;
                            end else begin
                                r_cfg_err <= 1'b1;
                            end
                        end
                    end
                    RESET_CU: begin
                        if (r_phase) begin
                            r_reset_top <= 1'b1;
                            r_wd        <= 24'd0;
                            r_state     <= WAIT_CU_IDLE;
                        end else begin
                            r_phase <= 1'b1;
                        end
                    end
                    WAIT_CU_IDLE: begin
                        r_wd <= w_wd_next;
                        if (w_timeout) begin
                            r_timeout_err <= 1'b1;
                            r_reset_top   <= 1'b0;
                            r_load        <= 1'b0;
                            r_phase       <= 1'b0;
                            r_state       <= ABORT;
                        end else if (slave_select && Kernel_BRAM_IDLE) begin
                            r_load  <= 1'b1;
                            r_state <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        r_wd <= w_wd_next;
                        if (w_timeout) begin
                            r_timeout_err <= 1'b1;
                            r_reset_top   <= 1'b0;
                            r_load        <= 1'b0;
                            r_phase       <= 1'b0;
                            r_state       <= ABORT;
                        end else if (!slave_select) begin
                            r_load  <= 1'b0;
                            r_state <= RUN;
                        end
                    end
                    RUN: begin
                        // a kernel that completes on the watchdog's last cycle still counts
                        r_wd <= w_wd_next;
                        if (conv_DONE) begin
                            r_state <= NEXT;
                        end else if (w_timeout) begin
                            r_timeout_err <= 1'b1;
                            r_reset_top   <= 1'b0;
                            r_load        <= 1'b0;
                            r_phase       <= 1'b0;
                            r_state       <= ABORT;
                        end
                    end
                    NEXT: begin
                        if (r_idx == w_last_idx) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_idx   <= r_idx + 9'd1;
                            r_wd    <= 24'd0;
                            r_state <= WAIT_CU_IDLE;
                        end
                    end
                    DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                    ABORT: begin
                        if (r_phase) begin
                            r_reset_top <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= IDLE;
                        end else begin
                            r_phase <= 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign Reset_top           = r_reset_top;
    assign Load_kernel_BRAM    = r_load;
    assign CHANNEL_SIZE_choose = r_chan;
    assign IMAGE_SIZE_choose   = r_img;
    assign out_ch_index        = r_idx;
    assign layer_busy          = r_busy;
    assign layer_done          = r_done;
    assign cfg_err             = r_cfg_err;
    assign timeout_err         = r_timeout_err;

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// tb/tb_conv_layer_scheduler.sv - self-checking bench for conv_layer_scheduler
// A small CU model drives the handshake; expectations come from the layer-level rules.
module tb_conv_layer_scheduler;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] cfg_chan_choose = 2'd0;
    logic [2:0] cfg_img_choose = 3'd0;
    logic [8:0] cfg_out_ch = 9'd1;
    logic       slave_select = 1'b0;
    logic       Kernel_BRAM_IDLE = 1'b0;
    logic       conv_DONE = 1'b0;
    logic       Reset_top;
    logic       Load_kernel_BRAM;
    logic [1:0] CHANNEL_SIZE_choose;
    logic [2:0] IMAGE_SIZE_choose;
    logic [8:0] out_ch_index;
    logic       layer_busy;
    logic       layer_done;
    logic       cfg_err;
    logic       timeout_err;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    logic prev_load = 1'b0;
    int q_load[$];

    conv_layer_scheduler #(.TIMEOUT_CYCLES(24'd100)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_chan_choose(cfg_chan_choose), .cfg_img_choose(cfg_img_choose),
        .cfg_out_ch(cfg_out_ch), .slave_select(slave_select),
        .Kernel_BRAM_IDLE(Kernel_BRAM_IDLE), .conv_DONE(conv_DONE),
        .Reset_top(Reset_top), .Load_kernel_BRAM(Load_kernel_BRAM),
        .CHANNEL_SIZE_choose(CHANNEL_SIZE_choose), .IMAGE_SIZE_choose(IMAGE_SIZE_choose),
        .out_ch_index(out_ch_index), .layer_busy(layer_busy), .layer_done(layer_done),
        .cfg_err(cfg_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Records the kernel index at every load request and counts layer_done cycles.
    always @(negedge clk) begin
        if (Load_kernel_BRAM === 1'b1 && !prev_load) q_load.push_back(int'(out_ch_index));
        prev_load <= (Load_kernel_BRAM === 1'b1);
        if (layer_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic count_reset_low(input string tag);
        int lo = 0;
        int w = 0;
        while (Reset_top === 1'b0 && w < 10) begin
            lo++;
            tick();
            w++;
        end
        check(tag, lo, 2);
    endtask

    task automatic start_layer(input int chan, input int img, input int n);
        cfg_chan_choose = 2'(chan);
        cfg_img_choose  = 3'(img);
        cfg_out_ch      = 9'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", layer_busy, 1);
        check("start_timeout_clr", timeout_err, 0);
        count_reset_low("rst_cu_len");
    endtask

    task automatic kernel(input int exp_idx, input int hold, input int run_len, input bit do_done);
        int w = 0;
        int hcnt;
        slave_select = 1'b1;
        Kernel_BRAM_IDLE = 1'b1;
        while (Load_kernel_BRAM !== 1'b1 && w < 200) begin
            tick();
            w++;
        end
        check("load_wait_bound", (w < 200), 1);
        check("idx_at_load", out_ch_index, exp_idx);
        hcnt = 1;
        for (int k = 1; k < hold; k++) begin
            tick();
            if (Load_kernel_BRAM === 1'b1) hcnt++;
        end
        slave_select = 1'b0;
        Kernel_BRAM_IDLE = 1'b0;
        tick();
        check("load_len", hcnt, hold);
        check("load_drop", Load_kernel_BRAM, 0);
        for (int k = 1; k < run_len; k++) tick();
        if (do_done) begin
            conv_DONE = 1'b1;
            tick();
            conv_DONE = 1'b0;
        end
    endtask

    task automatic run_layer(input int chan, input int img, input int n, input int hold0,
                             input int hmax, input int rmax, input int pulse_at);
        int l0 = q_load.size();
        int d0 = done_cnt;
        int bad = -1;
        int w = 0;
        start_layer(chan, img, n);
        for (int k = 0; k < n; k++) begin
            if (k == pulse_at) begin
                cfg_chan_choose = 2'd2;
                start = 1'b1;
                tick();
                start = 1'b0;
                check("mid_start_no_err", cfg_err, 0);
                check("mid_start_busy", layer_busy, 1);
            end
            kernel(k, (k == 0 && hold0 > 0) ? hold0 : $urandom_range(1, hmax),
                   (k == 0 && hold0 > 0) ? 50 : $urandom_range(1, rmax), 1'b1);
        end
        while (layer_busy === 1'b1 && w < 20) begin
            tick();
            w++;
        end
        check("layer_end_bound", (w < 20), 1);
        check("load_count", q_load.size() - l0, n);
        for (int k = 0; k < n; k++)
            if (bad < 0 && q_load.size() > l0 + k && q_load[l0 + k] != k) bad = k;
        check("load_idx_seq_first_bad", bad, -1);
        check("done_count", done_cnt - d0, 1);
        check("chan_latched", CHANNEL_SIZE_choose, chan);
        check("img_latched", IMAGE_SIZE_choose, img);
        check("final_idx", out_ch_index, n - 1);
        check("end_reset_top", Reset_top, 1);
    endtask

    task automatic invalid_start(input int chan, input int img, input int n,
                                 input int exp_chan, input int exp_img);
        int l0 = q_load.size();
        cfg_chan_choose = 2'(chan);
        cfg_img_choose  = 3'(img);
        cfg_out_ch      = 9'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("cfg_err_pulse", cfg_err, 1);
        check("cfg_err_busy", layer_busy, 0);
        tick();
        check("cfg_err_one_cycle", cfg_err, 0);
        check("cfg_err_busy2", layer_busy, 0);
        check("cfg_err_chan_kept", CHANNEL_SIZE_choose, exp_chan);
        check("cfg_err_img_kept", IMAGE_SIZE_choose, exp_img);
        check("cfg_err_no_load", q_load.size() - l0, 0);
    endtask

    initial begin
        int c;
        int d0;
        int w;
        tick();
        tick();
        check("rst_Reset_top", Reset_top, 0);
        check("rst_load", Load_kernel_BRAM, 0);
        check("rst_chan", CHANNEL_SIZE_choose, 0);
        check("rst_img", IMAGE_SIZE_choose, 0);
        check("rst_idx", out_ch_index, 0);
        check("rst_busy", layer_busy, 0);
        check("rst_done", layer_done, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_timeout", timeout_err, 0);
        reset = 1'b0;
        tick();
        check("rst_release_top", Reset_top, 1);

        // normal layer: 3 kernels, first load handshake held 7 cycles
        run_layer(1, 2, 3, 7, 8, 50, -1);

        invalid_start(2, 6, 3, 1, 2);
        invalid_start(0, 3, 0, 1, 2);
        invalid_start(3, 1, 5, 1, 2);
        invalid_start(1, 1, 257 + $urandom_range(0, 200), 1, 2);

        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort_busy", layer_busy, 0);
        check("idle_abort_top", Reset_top, 1);

        for (int r = 0; r < 3; r++)
            run_layer($urandom_range(0, 2), $urandom_range(0, 5), $urandom_range(1, 4), 0, 8, 50, -1);

        // watchdog: CU takes the load but never finishes
        d0 = done_cnt;
        start_layer(0, 0, 2);
        c = 1;
        slave_select = 1'b1;
        Kernel_BRAM_IDLE = 1'b1;
        while (timeout_err !== 1'b1 && c < 300) begin
            tick();
            c++;
            if (Load_kernel_BRAM === 1'b1) begin
                slave_select = 1'b0;
                Kernel_BRAM_IDLE = 1'b0;
            end
        end
        check("timeout_cycle", c - 1, 100);
        check("timeout_load_off", Load_kernel_BRAM, 0);
        count_reset_low("timeout_reset_len");
        check("timeout_busy", layer_busy, 0);
        tick();
        tick();
        check("timeout_sticky", timeout_err, 1);
        check("timeout_no_done", done_cnt - d0, 0);

        // abort during RUN of kernel 1, coinciding with conv_DONE
        d0 = done_cnt;
        start_layer(1, 1, 3);
        kernel(0, $urandom_range(1, 8), $urandom_range(1, 20), 1'b1);
        kernel(1, $urandom_range(1, 8), 5, 1'b0);
        abort = 1'b1;
        conv_DONE = 1'b1;
        tick();
        abort = 1'b0;
        conv_DONE = 1'b0;
        check("abort_top", Reset_top, 0);
        check("abort_load", Load_kernel_BRAM, 0);
        check("abort_no_timeout", timeout_err, 0);
        check("abort_idx", out_ch_index, 1);
        count_reset_low("abort_reset_len");
        check("abort_busy", layer_busy, 0);
        check("abort_no_done", done_cnt - d0, 0);

        // largest layer, with a start pulse ignored halfway through
        run_layer(0, 4, 256, 0, 3, 4, 100);

        // reset in the middle of a layer
        d0 = done_cnt;
        start_layer(2, 5, 2);
        kernel(0, $urandom_range(1, 8), 5, 1'b0);
        reset = 1'b1;
        tick();
        check("midrst_top", Reset_top, 0);
        check("midrst_load", Load_kernel_BRAM, 0);
        check("midrst_chan", CHANNEL_SIZE_choose, 0);
        check("midrst_img", IMAGE_SIZE_choose, 0);
        check("midrst_idx", out_ch_index, 0);
        check("midrst_busy", layer_busy, 0);
        check("midrst_done", layer_done, 0);
        check("midrst_cfg_err", cfg_err, 0);
        check("midrst_timeout", timeout_err, 0);
        reset = 1'b0;
        tick();
        check("midrst_release_top", Reset_top, 1);
        w = 0;
        while (w < 3) begin
            tick();
            w++;
        end
        check("midrst_no_done", done_cnt - d0, 0);

        run_layer($urandom_range(0, 2), $urandom_range(0, 5), $urandom_range(1, 4), 0, 8, 50, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
